// File: rtl/unidade_controle_pkg.sv
// Shared game definitions: state codes, control-output bundle and Moore decode.
// Used by the control unit and by anything that needs to read db_estado.
package unidade_controle_pkg;

    localparam int unsigned ESTADO_W = 5;

    typedef enum logic [ESTADO_W-1:0] {
        INICIAL         = 5'h00,
        PREPARACAO      = 5'h01,
        INICIO_RODADA   = 5'h02,
        MOSTRA_LED      = 5'h03,
        PROXIMO_LED     = 5'h04,
        INICIO_JOGADAS  = 5'h05,
        ESPERA_JOGADA   = 5'h06,
        REGISTRA        = 5'h07,
        COMPARACAO      = 5'h08,
        PROXIMA_JOGADA  = 5'h09,
        PREPARA_ESCRITA = 5'h0A,
        ESPERA_ESCRITA  = 5'h0B,
        ESCREVE         = 5'h0C,
        PROXIMA_RODADA  = 5'h0D,
        ACERTOU         = 5'h0E,
        ERROU           = 5'h0F,
        FIM_TIMEOUT     = 5'h10
    } estado_t;

    // Every control strobe the datapath expects from the control unit.
    typedef struct packed {
        logic zera_endereco;
        logic conta_endereco;
        logic zera_limite;
        logic conta_limite;
        logic zera_r;
        logic registrar_r;
        logic zera_modo;
        logic registra_modo;
        logic zera_s_timeout;
        logic enable_timeout;
        logic zera_s_led;
        logic enable_led;
        logic conf_leds;
        logic registra_jogada;
        logic pronto;
        logic ganhou;
        logic perdeu;
    } saidas_t;

    // Game-over states wait for a new iniciar.
    function automatic logic eh_terminal(input estado_t estado);
        return (estado == ACERTOU) || (estado == ERROU) || (estado == FIM_TIMEOUT);
    endfunction

    // Output decode of the current state. The address only advances in
    // proximo_led while the shown sequence is not yet complete; the play
    // timeout only runs when the registered configuration enables it.
    function automatic saidas_t decodifica_saidas(
        input estado_t estado,
        input logic    fim_sequencia,
        input logic    timeout_habilitado
    );
        saidas_t s;
        s = '0;
        case (estado)
            PREPARACAO: begin
                s.zera_endereco  = 1'b1;
                s.zera_limite    = 1'b1;
                s.zera_r         = 1'b1;
                s.zera_s_timeout = 1'b1;
                s.zera_s_led     = 1'b1;
                s.registra_modo  = 1'b1;
            end
            INICIO_RODADA: begin
                s.zera_endereco = 1'b1;
                s.zera_s_led    = 1'b1;
            end
            MOSTRA_LED: begin
                s.conf_leds  = 1'b1;
                s.enable_led = 1'b1;
            end
            PROXIMO_LED: begin
                s.zera_s_led     = 1'b1;
                s.conta_endereco = ~fim_sequencia;
            end
            INICIO_JOGADAS: begin
                s.zera_endereco  = 1'b1;
                s.zera_s_timeout = 1'b1;
            end
            ESPERA_JOGADA, ESPERA_ESCRITA: begin
                s.enable_timeout = timeout_habilitado;
            end
            REGISTRA: begin
                s.registrar_r = 1'b1;
            end
            PROXIMA_JOGADA, PREPARA_ESCRITA: begin
                s.conta_endereco = 1'b1;
                s.zera_s_timeout = 1'b1;
            end
            ESCREVE: begin
                s.registra_jogada = 1'b1;
            end
            PROXIMA_RODADA: begin
                s.conta_limite = 1'b1;
            end
            ACERTOU: begin
                s.pronto = 1'b1;
                s.ganhou = 1'b1;
            end
            ERROU, FIM_TIMEOUT: begin
                s.pronto = 1'b1;
                s.perdeu = 1'b1;
            end
            default: begin
                s = '0;
            end
        endcase
        return s;
    endfunction

endpackage

// File: rtl/unidade_controle.sv
// Control unit of the colour-memory game: one state per clock, Moore-style
// strobes decoded from the state register for the datapath.
module unidade_controle
    import unidade_controle_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_iniciar,
    input  logic                i_igual,
    input  logic                i_fim_jogo,
    input  logic                i_fim_sequencia,
    input  logic                i_jogada_feita,
    input  logic                i_timeout,
    input  logic                i_timeout_led,
    input  logic                i_timeout_habilitado,
    output logic                o_zera_endereco,
    output logic                o_conta_endereco,
    output logic                o_zera_limite,
    output logic                o_conta_limite,
    output logic                o_zera_r,
    output logic                o_registrar_r,
    output logic                o_zera_modo,
    output logic                o_registra_modo,
    output logic                o_zera_s_timeout,
    output logic                o_enable_timeout,
    output logic                o_zera_s_led,
    output logic                o_enable_led,
    output logic                o_conf_leds,
    output logic                o_registra_jogada,
    output logic                o_pronto,
    output logic                o_ganhou,
    output logic                o_perdeu,
    output logic [ESTADO_W-1:0] o_db_estado
);

    estado_t r_estado;
    estado_t w_proximo;
    saidas_t w_saidas;
    logic    w_expirou;

    // The play timeout only ends the game when timeouts are enabled.
    assign w_expirou = i_timeout & i_timeout_habilitado;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_estado <= INICIAL;
        end else begin
            r_estado <= w_proximo;
        end
    end

    // Next-state logic; a button press takes priority over an expiring timeout.
    always_comb begin
        w_proximo = r_estado;
        case (r_estado)
            INICIAL: begin
                if (i_iniciar) w_proximo = PREPARACAO;
            end
            PREPARACAO:      w_proximo = INICIO_RODADA;
            INICIO_RODADA:   w_proximo = MOSTRA_LED;
            MOSTRA_LED: begin
                if (i_timeout_led) w_proximo = PROXIMO_LED;
            end
            PROXIMO_LED: begin
                w_proximo = i_fim_sequencia ? INICIO_JOGADAS : MOSTRA_LED;
            end
            INICIO_JOGADAS:  w_proximo = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                if (i_jogada_feita)  w_proximo = REGISTRA;
                else if (w_expirou)  w_proximo = FIM_TIMEOUT;
            end
            REGISTRA:        w_proximo = COMPARACAO;
            COMPARACAO: begin
                if (!i_igual)                          w_proximo = ERROU;
                else if (i_fim_sequencia && i_fim_jogo) w_proximo = ACERTOU;
                else if (i_fim_sequencia)              w_proximo = PREPARA_ESCRITA;
                else                                   w_proximo = PROXIMA_JOGADA;
            end
            PROXIMA_JOGADA:  w_proximo = ESPERA_JOGADA;
            PREPARA_ESCRITA: w_proximo = ESPERA_ESCRITA;
            ESPERA_ESCRITA: begin
                if (i_jogada_feita)  w_proximo = ESCREVE;
                else if (w_expirou)  w_proximo = FIM_TIMEOUT;
            end
            ESCREVE:         w_proximo = PROXIMA_RODADA;
            PROXIMA_RODADA:  w_proximo = INICIO_RODADA;
            ACERTOU, ERROU, FIM_TIMEOUT: begin
                if (i_iniciar) w_proximo = PREPARACAO;
            end
            default:         w_proximo = INICIAL;
        endcase
    end

    // Output decode from the current state only.
    always_comb begin
        w_saidas = decodifica_saidas(r_estado, i_fim_sequencia, i_timeout_habilitado);
    end

    assign o_zera_endereco   = w_saidas.zera_endereco;
    assign o_conta_endereco  = w_saidas.conta_endereco;
    assign o_zera_limite     = w_saidas.zera_limite;
    assign o_conta_limite    = w_saidas.conta_limite;
    assign o_zera_r          = w_saidas.zera_r;
    assign o_registrar_r     = w_saidas.registrar_r;
    assign o_zera_modo       = w_saidas.zera_modo;
    assign o_registra_modo   = w_saidas.registra_modo;
    assign o_zera_s_timeout  = w_saidas.zera_s_timeout;
    assign o_enable_timeout  = w_saidas.enable_timeout;
    assign o_zera_s_led      = w_saidas.zera_s_led;
    assign o_enable_led      = w_saidas.enable_led;
    assign o_conf_leds       = w_saidas.conf_leds;
    assign o_registra_jogada = w_saidas.registra_jogada;
    assign o_pronto          = w_saidas.pronto;
    assign o_ganhou          = w_saidas.ganhou;
    assign o_perdeu          = w_saidas.perdeu;
    assign o_db_estado       = ESTADO_W'(r_estado);

endmodule

// File: tb/tb_unidade_controle.sv
// Scoreboard bench for unidade_controle: driver predicts state and strobes from
// the game rules, monitor compares on the falling edge.
module tb_unidade_controle;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iniciar = 1'b0, igual = 1'b0, fim_jogo = 1'b0, fim_sequencia = 1'b0;
    logic       jogada_feita = 1'b0, timeout = 1'b0, timeout_led = 1'b0, timeout_habilitado = 1'b0;
    logic       zera_endereco, conta_endereco, zera_limite, conta_limite;
    logic       zera_r, registrar_r, zera_modo, registra_modo;
    logic       zera_s_timeout, enable_timeout, zera_s_led, enable_led;
    logic       conf_leds, registra_jogada, pronto, ganhou, perdeu;
    logic [4:0] db_estado;

    int checks = 0;
    int errors = 0;
    int model_state = 0;
    logic [21:0] exp_q[$];

    always #5 clk = ~clk;

    unidade_controle dut (
        .i_clk(clk), .i_rst(rst), .i_iniciar(iniciar), .i_igual(igual),
        .i_fim_jogo(fim_jogo), .i_fim_sequencia(fim_sequencia),
        .i_jogada_feita(jogada_feita), .i_timeout(timeout),
        .i_timeout_led(timeout_led), .i_timeout_habilitado(timeout_habilitado),
        .o_zera_endereco(zera_endereco), .o_conta_endereco(conta_endereco),
        .o_zera_limite(zera_limite), .o_conta_limite(conta_limite),
        .o_zera_r(zera_r), .o_registrar_r(registrar_r),
        .o_zera_modo(zera_modo), .o_registra_modo(registra_modo),
        .o_zera_s_timeout(zera_s_timeout), .o_enable_timeout(enable_timeout),
        .o_zera_s_led(zera_s_led), .o_enable_led(enable_led),
        .o_conf_leds(conf_leds), .o_registra_jogada(registra_jogada),
        .o_pronto(pronto), .o_ganhou(ganhou), .o_perdeu(perdeu),
        .o_db_estado(db_estado)
    );

    // Per-output membership: each strobe is high only in the states named for it.
    function automatic logic [16:0] expected_outputs(input int s, input logic fs, input logic th);
        logic [16:0] v;
        v[16] = (s == 1) || (s == 2) || (s == 5);            // zera_endereco
        v[15] = ((s == 4) && !fs) || (s == 9) || (s == 10);  // conta_endereco
        v[14] = (s == 1);                                    // zera_limite
        v[13] = (s == 13);                                   // conta_limite
        v[12] = (s == 1);                                    // zeraR
        v[11] = (s == 7);                                    // registrarR
        v[10] = 1'b0;                                        // zera_modo
        v[9]  = (s == 1);                                    // registra_modo
        v[8]  = (s == 1) || (s == 5) || (s == 9) || (s == 10); // zera_s_timeout
        v[7]  = ((s == 6) || (s == 11)) && th;               // enable_timeout
        v[6]  = (s == 1) || (s == 2) || (s == 4);            // zera_s_led
        v[5]  = (s == 3);                                    // enable_led
        v[4]  = (s == 3);                                    // conf_leds
        v[3]  = (s == 12);                                   // registra_jogada
        v[2]  = (s == 14) || (s == 15) || (s == 16);         // pronto
        v[1]  = (s == 14);                                   // ganhou
        v[0]  = (s == 15) || (s == 16);                      // perdeu
        return v;
    endfunction

    // Game rules: where the game goes after one clock from state s.
    function automatic int next_state(input int s, input logic ini, input logic ig,
                                      input logic fj, input logic fs, input logic jf,
                                      input logic to, input logic tl, input logic th);
        case (s)
            0:       return ini ? 1 : 0;
            1:       return 2;
            2:       return 3;
            3:       return tl ? 4 : 3;
            4:       return fs ? 5 : 3;
            5:       return 6;
            6:       return jf ? 7 : ((to && th) ? 16 : 6);
            7:       return 8;
            8:       return !ig ? 15 : ((fs && fj) ? 14 : (fs ? 10 : 9));
            9:       return 6;
            10:      return 11;
            11:      return jf ? 12 : ((to && th) ? 16 : 11);
            12:      return 13;
            13:      return 2;
            14, 15, 16: return ini ? 1 : s;
            default: return 0;
        endcase
    endfunction

    // Drive one cycle of inputs just after the rising edge and predict the result.
    task automatic step(input logic rs, input logic ini, input logic ig, input logic fj,
                        input logic fs, input logic jf, input logic to, input logic tl,
                        input logic th);
        @(posedge clk);
        #1;
        rst = rs; iniciar = ini; igual = ig; fim_jogo = fj; fim_sequencia = fs;
        jogada_feita = jf; timeout = to; timeout_led = tl; timeout_habilitado = th;
        if (rs) model_state = 0;
        exp_q.push_back({5'(model_state), expected_outputs(model_state, fs, th)});
        model_state = rs ? 0 : next_state(model_state, ini, ig, fj, fs, jf, to, tl, th);
    endtask

    // Monitor: compare the DUT against the oldest prediction on every falling edge.
    initial begin
        logic [21:0] exp_v;
        logic [21:0] got_v;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                got_v = {db_estado, zera_endereco, conta_endereco, zera_limite, conta_limite,
                         zera_r, registrar_r, zera_modo, registra_modo, zera_s_timeout,
                         enable_timeout, zera_s_led, enable_led, conf_leds, registra_jogada,
                         pronto, ganhou, perdeu};
                checks++;
                if (got_v !== exp_v) begin
                    errors++;
                    $display("FAIL state_outputs t=%0t got estado=%h out=%b required estado=%h out=%b",
                             $time, got_v[21:17], got_v[16:0], exp_v[21:17], exp_v[16:0]);
                end
            end
        end
    end

    initial begin
        int hold_rst;
        logic r;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // start, show one LED after three display cycles, enter play
        step(0, 1, 1, 0, 1, 0, 0, 0, 1);
        step(0, 0, 1, 0, 1, 0, 0, 0, 1);
        step(0, 0, 1, 0, 1, 0, 0, 0, 1);
        step(0, 0, 1, 0, 1, 0, 0, 0, 1);
        step(0, 0, 1, 0, 1, 0, 0, 1, 1);
        step(0, 0, 1, 0, 1, 0, 0, 0, 1);
        step(0, 0, 1, 0, 1, 0, 0, 0, 1);
        step(0, 0, 1, 0, 1, 0, 0, 0, 1);
        // correct play, not last of the sequence
        step(0, 0, 1, 0, 0, 1, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0, 0, 0, 1);
        // press and timeout together, last of sequence, then write a new colour
        step(0, 0, 1, 0, 1, 1, 1, 0, 1);
        step(0, 0, 1, 0, 1, 0, 0, 0, 1);
        step(0, 0, 1, 0, 1, 0, 0, 0, 1);
        step(0, 0, 1, 0, 1, 0, 0, 0, 1);
        step(0, 0, 1, 0, 1, 0, 0, 0, 1);
        step(0, 0, 1, 0, 1, 1, 0, 0, 1);
        step(0, 0, 1, 0, 1, 0, 0, 0, 1);
        step(0, 0, 1, 0, 1, 0, 0, 0, 1);
        step(0, 0, 1, 0, 1, 0, 0, 0, 1);
        // now in mostra_led: asynchronous reset mid-display
        step(1, 0, 1, 0, 1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        // run to espera_jogada, then a lone timeout ends the game
        step(0, 1, 1, 0, 1, 0, 0, 1, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 1, 0, 0, 1, 1);
        step(0, 0, 1, 0, 1, 0, 1, 0, 1);
        step(0, 0, 1, 0, 1, 0, 0, 0, 1);
        step(0, 0, 1, 0, 1, 0, 0, 0, 1);
        // restart, miss a play, restart, win
        step(0, 1, 1, 0, 1, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 1, 1, 1, 1, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 1, 1, 0, 0, 1, 0);
        step(0, 0, 1, 1, 1, 1, 0, 0, 0);
        step(0, 0, 1, 1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 1, 0, 0, 0, 0);
        step(0, 1, 1, 1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 1, 0, 0, 0, 0);

        // randomized play with occasional resets landing in any state
        hold_rst = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold_rst > 0) begin
                hold_rst--;
            end else if ($urandom_range(0, 99) == 0) begin
                hold_rst = int'($urandom_range(1, 2));
            end
            r = (hold_rst > 0);
            step(r,
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
